// File: rtl/ahb_apb_bridge_mc.sv
// AHB-Lite slave to APB master bridge for NUM_SLV one-hot selected peripherals.
// Registered outputs; two-cycle AHB ERROR on slave error, decode/size miss or APB timeout.
module ahb_apb_bridge_mc #(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                HCLK,
  input  logic                HRSTn,
  input  logic                HSEL,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [31:0]         HWDATA,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [31:0]         HRDATA,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [NUM_SLV-1:0]  PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [31:0]         PWDATA,
  output logic [3:0]          PSTRB,
  input  logic [31:0]         PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int SEL_W = $clog2(NUM_SLV);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WDATA  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_ERR1   = 3'd4;
  localparam logic [2:0] S_ERR2   = 3'd5;

  logic [2:0]         state;
  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic [2:0]         size_q;
  logic [CNT_W-1:0]   wait_cnt;

  logic               accept;
  logic               enter_setup;
  logic               timeout_hit;
  logic [ADDR_W-1:0]  src_addr;
  logic               src_write;
  logic [2:0]         src_size;
  logic [SEL_W-1:0]   src_idx;
  logic               src_bad;
  logic [3:0]         src_strb;
  logic [NUM_SLV-1:0] src_sel;
  logic               unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  assign accept = ((state == S_IDLE) || (state == S_ERR2)) && HSEL && HREADY && HTRANS[1];

  // Reads go straight to SETUP from the live address phase; writes use the captured copy.
  always_comb begin
    src_addr  = HADDR;
    src_write = HWRITE;
    src_size  = HSIZE;
    if (state == S_WDATA) begin
      src_addr  = addr_q;
      src_write = write_q;
      src_size  = size_q;
    end
    src_idx = src_addr[ADDR_W-1 -: SEL_W];
    src_bad = 1'b0;
    if (src_size > 3'd2)
      src_bad = 1'b1;
    if ((src_size == 3'd1) && src_addr[0])
      src_bad = 1'b1;
    if ((src_size == 3'd2) && (src_addr[1:0] != 2'b00))
      src_bad = 1'b1;
    if ({1'b0, src_idx} >= (SEL_W+1)'(NUM_SLV))
      src_bad = 1'b1;
    src_strb = 4'b1111;
    case (src_size[1:0])
      2'd0:    src_strb = 4'b0001 << src_addr[1:0];
      2'd1:    src_strb = src_addr[1] ? 4'b1100 : 4'b0011;
      default: src_strb = 4'b1111;
    endcase
    if (!src_write)
      src_strb = 4'b0000;
    src_sel = {{(NUM_SLV-1){1'b0}}, 1'b1} << src_idx;
  end

  assign enter_setup = (accept && !src_bad && !HWRITE) || (state == S_WDATA);
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge HCLK) begin
    if (!HRSTn) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= 3'd0;
      wait_cnt  <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= 32'd0;
      PADDR     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= 32'd0;
      PSTRB     <= 4'd0;
    end else begin
      case (state)
        S_IDLE, S_ERR2: begin
          if (accept) begin
            addr_q    <= HADDR;
            write_q   <= HWRITE;
            size_q    <= HSIZE;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b0;
            if (src_bad) begin
              state <= S_ERR1;
              HRESP <= 1'b1;
            end else if (HWRITE) begin
              state <= S_WDATA;
            end else begin
              state <= S_SETUP;
            end
          end else if (state == S_ERR2) begin
            state <= S_IDLE;
            HRESP <= 1'b0;
          end
        end
        S_WDATA: begin
          PWDATA <= HWDATA;
          state  <= S_SETUP;
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            if (PSLVERR) begin
              state <= S_ERR1;
              HRESP <= 1'b1;
            end else begin
              state     <= S_IDLE;
              HREADYOUT <= 1'b1;
              if (!write_q)
                HRDATA <= PRDATA;
            end
          end else if (timeout_hit) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= S_ERR1;
            HRESP   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          HREADYOUT <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      if (enter_setup) begin
        state    <= S_SETUP;
        wait_cnt <= '0;
        PSEL     <= src_sel;
        PADDR    <= src_addr;
        PWRITE   <= src_write;
        PSTRB    <= src_strb;
      end
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_mc.sv
// Bench for ahb_apb_bridge_mc: directed plan items then randomized transfers vs a transaction-level model.
module tb_ahb_apb_bridge_mc;

  localparam int NS = 3;
  localparam int TO = 4;

  logic          HCLK = 1'b0;
  logic          HRSTn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [31:0]   PADDR;
  logic [NS-1:0] PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [3:0]    PSTRB;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_hrdata;

  ahb_apb_bridge_mc #(.ADDR_W(32), .NUM_SLV(NS), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRSTn(HRSTn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One AHB transfer, started at a negedge; returns at the negedge where HREADYOUT=1 is seen.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, input int nwait, input logic slverr,
                      input logic [31:0] prdata);
    int idx, lane, nb, acc_exp, ready_exp, ready_k, setups, accs;
    logic is_bad, is_err, hr1, prev_resp, resp_rdy, multi;
    logic [3:0] strb_exp;
    logic [NS-1:0] psel_obs;
    logic [31:0] paddr_obs, pwdata_obs;
    logic [3:0] pstrb_obs;
    logic pwrite_obs;

    idx  = int'(addr[31:30]);
    lane = int'(addr[1:0]);
    nb   = 1 << size;
    is_bad = (size > 3'd2) || (size == 3'd1 && addr[0]) ||
             (size == 3'd2 && addr[1:0] != 2'b00) || (idx >= NS);
    for (int b = 0; b < 4; b++)
      strb_exp[b] = wr && (b >= lane) && (b < lane + nb);
    is_err  = is_bad || (nwait >= TO) || slverr;
    acc_exp = is_bad ? 0 : ((nwait >= TO) ? TO : nwait + 1);
    ready_exp = is_bad ? 2 : (2 + int'(wr) + acc_exp + int'(is_err));
    if (!is_err && !wr)
      model_hrdata = prdata;

    HSEL = 1'b1; HADDR = addr; HTRANS = 2'b10; HWRITE = wr; HSIZE = size;
    @(posedge HCLK);
    #1;
    HTRANS = 2'b00; HSEL = 1'b0; HWDATA = wdata;
    HADDR = $urandom; HWRITE = $urandom_range(0, 1); HSIZE = 3'($urandom_range(0, 7));

    ready_k = 0; setups = 0; accs = 0; multi = 1'b0; hr1 = 1'b1;
    prev_resp = 1'b0; resp_rdy = 1'b0; psel_obs = '0;
    paddr_obs = '0; pwdata_obs = '0; pstrb_obs = '0; pwrite_obs = 1'b0;
    for (int k = 1; k <= 60 && ready_k == 0; k++) begin
      @(negedge HCLK);
      if (k == 1) hr1 = HREADYOUT;
      if ($countones(PSEL) > 1) multi = 1'b1;
      if (PSEL != '0 && !PENABLE) begin
        setups++;
        psel_obs = PSEL;
      end
      if (PSEL != '0 && PENABLE) begin
        accs++;
        paddr_obs = PADDR; pwdata_obs = PWDATA; pstrb_obs = PSTRB; pwrite_obs = PWRITE;
      end
      if (HREADYOUT) begin
        ready_k  = k;
        resp_rdy = HRESP;
      end else begin
        prev_resp = HRESP;
      end
      if (PSEL != '0 && PENABLE) begin
        PREADY  = (accs - 1 >= nwait);
        PSLVERR = slverr && PREADY;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end
      PRDATA = prdata;
    end
    PREADY = 1'b0; PSLVERR = 1'b0;

    chk("hreadyout_t1", 32'(hr1), 32'd0);
    chk("ready_latency", 32'(ready_k), 32'(ready_exp));
    chk("hresp_ready", 32'(resp_rdy), 32'(is_err));
    chk("hresp_before_ready", 32'(prev_resp), 32'(is_err));
    chk("setup_cycles", 32'(setups), is_bad ? 32'd0 : 32'd1);
    chk("access_cycles", 32'(accs), 32'(acc_exp));
    chk("psel_multi", 32'(multi), 32'd0);
    chk("hrdata", HRDATA, model_hrdata);
    if (!is_bad) begin
      chk("psel_onehot", 32'(psel_obs), 32'(1 << idx));
      chk("paddr", paddr_obs, addr);
      chk("pwrite", 32'(pwrite_obs), 32'(wr));
      chk("pstrb", 32'(pstrb_obs), 32'(strb_exp));
      if (wr) chk("pwdata", pwdata_obs, wdata);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hreadyout"}, 32'(HREADYOUT), 32'd1);
    chk({tag, "_hresp"}, 32'(HRESP), 32'd0);
    chk({tag, "_hrdata"}, HRDATA, 32'd0);
    chk({tag, "_psel"}, 32'(PSEL), 32'd0);
    chk({tag, "_penable"}, 32'(PENABLE), 32'd0);
    chk({tag, "_paddr"}, PADDR, 32'd0);
    chk({tag, "_pwrite"}, 32'(PWRITE), 32'd0);
    chk({tag, "_pwdata"}, PWDATA, 32'd0);
    chk({tag, "_pstrb"}, 32'(PSTRB), 32'd0);
  endtask

  initial begin
    int seen;
    HRSTn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd0; HWDATA = '0; HREADY = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    model_hrdata = 32'd0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk_reset_outputs("reset");
    HRSTn = 1'b1;
    @(negedge HCLK);

    // Plan: read slave 1, zero wait
    xfer(32'h4000_0010, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
    // Byte write to lane 3 with two wait states
    xfer(32'h0000_0003, 1'b1, 3'd0, 32'h1122_3344, 2, 1'b0, 32'h0);
    // Slave error, then a read presented during ERR2
    xfer(32'h8000_0008, 1'b1, 3'd1, 32'hCAFE_F00D, 1, 1'b1, 32'h0);
    xfer(32'h8000_0020, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h1234_5678);
    // Timeout with PREADY held low
    xfer(32'h4000_0004, 1'b0, 3'd2, 32'h0, 50, 1'b0, 32'h5555_AAAA);
    // Decode miss (idx 3 with three slaves) and misaligned word
    xfer(32'hC000_0000, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h9999_9999);
    xfer(32'h0000_0002, 1'b1, 3'd2, 32'hFFFF_0000, 0, 1'b0, 32'h0);
    // Back-to-back reads to two slaves
    xfer(32'h0000_0100, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'hA0A0_0001);
    xfer(32'h8000_0104, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'hB0B0_0002);
    // Halfword upper lane write
    xfer(32'h4000_0042, 1'b1, 3'd1, 32'h7777_8888, 0, 1'b0, 32'h0);

    // Reset during ACCESS
    HSEL = 1'b1; HADDR = 32'h8000_0004; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2;
    @(posedge HCLK);
    #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge HCLK);
      PREADY = 1'b0;
      if (PENABLE) seen = 1;
    end
    chk("reached_access", 32'(seen), 32'd1);
    HRSTn = 1'b0;
    @(posedge HCLK);
    #1;
    HRSTn = 1'b1;
    model_hrdata = 32'd0;
    chk_reset_outputs("midreset");
    @(negedge HCLK);
    chk("midreset_no_penable", 32'(PENABLE), 32'd0);
    xfer(32'h8000_0004, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0BAD_F00D);

    // Randomized transfers with optional idle/BUSY gaps
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      logic [2:0] sz;
      a = $urandom;
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 3'd2) a[1:0] = 2'b00;
        if (sz == 3'd1) a[0] = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        int gap;
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          HSEL = 1'($urandom_range(0, 1));
          HTRANS = HSEL ? 2'b01 : 2'($urandom_range(0, 3));
          HADDR = $urandom;
          @(negedge HCLK);
          chk("gap_hreadyout", 32'(HREADYOUT), 32'd1);
          chk("gap_hresp", 32'(HRESP), 32'd0);
        end
      end
      xfer(a, 1'($urandom_range(0, 1)), sz, $urandom, $urandom_range(0, 5),
           ($urandom_range(0, 7) == 0), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
